// File: rtl/rice_bus_sram_responder.sv
// rice_bus_sram_responder
//
// Responder end of the rice bus request/response handshake, backed by an
// internal byte-strobed word memory. Every accepted request returns exactly
// one response, in accept order, after a fixed pipeline of READ_LATENCY
// stages followed by a RESPONSE_DEPTH-entry response FIFO.
//
// Ports:
//   i_clk              clock
//   i_rst_n            asynchronous active-low reset
//   o_request_ready    request can be accepted this cycle (registered)
//   i_request_valid    request present
//   i_address          byte address (sub-word and upper bits ignored)
//   i_strobe           byte write enables; all-zero means read
//   i_write_data       write data
//   i_response_ready   initiator accepts the response
//   o_response_valid   response present (FIFO head valid)
//   o_read_data        response data; zero for writes and when empty
//
// Memory contents are not reset and survive a reset of the handshake logic.

module rice_bus_sram_responder #(
    parameter int ADDRESS_WIDTH  = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int WORD_COUNT     = 1024,
    parameter int READ_LATENCY   = 1,
    parameter int RESPONSE_DEPTH = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    output logic                      o_request_ready,
    input  logic                      i_request_valid,
    input  logic [ADDRESS_WIDTH-1:0]  i_address,
    input  logic [DATA_WIDTH/8-1:0]   i_strobe,
    input  logic [DATA_WIDTH-1:0]     i_write_data,
    input  logic                      i_response_ready,
    output logic                      o_response_valid,
    output logic [DATA_WIDTH-1:0]     o_read_data
);

    localparam int STROBE_WIDTH = DATA_WIDTH / 8;
    localparam int OFFSET_BITS  = $clog2(STROBE_WIDTH);
    localparam int INDEX_BITS   = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
    localparam int POINTER_BITS = (RESPONSE_DEPTH > 1) ? $clog2(RESPONSE_DEPTH) : 1;
    localparam int COUNT_BITS   = $clog2(RESPONSE_DEPTH + 1);

    localparam logic [COUNT_BITS-1:0]   DEPTH_COUNT  = COUNT_BITS'(RESPONSE_DEPTH);
    localparam logic [POINTER_BITS-1:0] LAST_POINTER = POINTER_BITS'(RESPONSE_DEPTH - 1);

    logic [DATA_WIDTH-1:0]   memory [WORD_COUNT];
    logic [INDEX_BITS-1:0]   word_index;
    logic                    accept;
    logic                    is_write;

    logic [READ_LATENCY-1:0] pipe_valid;
    logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];

    logic [DATA_WIDTH-1:0]   fifo_data [RESPONSE_DEPTH];
    logic [POINTER_BITS-1:0] write_pointer;
    logic [POINTER_BITS-1:0] read_pointer;
    logic [COUNT_BITS-1:0]   fifo_count;
    logic [COUNT_BITS-1:0]   fifo_count_next;
    logic                    push;
    logic                    pop;

    logic [COUNT_BITS-1:0]   outstanding;
    logic [COUNT_BITS-1:0]   outstanding_next;

    // Only the word-index slice of the address matters; the rest aliases.
    logic unused_address;
    assign unused_address = ^i_address;

    assign word_index = i_address[OFFSET_BITS +: INDEX_BITS];
    assign accept     = i_request_valid && o_request_ready;
    assign is_write   = |i_strobe;

    assign push = pipe_valid[READ_LATENCY-1];
    assign pop  = o_response_valid && i_response_ready;

    assign o_response_valid = (fifo_count != '0);
    assign o_read_data      = o_response_valid ? fifo_data[read_pointer] : '0;

    // Memory, pipeline payload and FIFO payload carry no reset; only the
    // valid/pointer/count state below decides what is visible.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            for (int b = 0; b < STROBE_WIDTH; b++) begin
                if (i_strobe[b]) begin
                    memory[word_index][8*b +: 8] <= i_write_data[8*b +: 8];
                end
            end
        end
        // Nonblocking read returns the word as it was before this edge, so a
        // write accepted on an earlier edge is already visible.
        pipe_data[0] <= is_write ? '0 : memory[word_index];
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_data[i] <= pipe_data[i-1];
        end
        if (push) begin
            fifo_data[write_pointer] <= pipe_data[READ_LATENCY-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= accept;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    always_comb begin
        fifo_count_next = fifo_count;
        case ({push, pop})
            2'b10:   fifo_count_next = fifo_count + COUNT_BITS'(1);
            2'b01:   fifo_count_next = fifo_count - COUNT_BITS'(1);
            default: fifo_count_next = fifo_count;
        endcase
    end

    always_comb begin
        outstanding_next = outstanding;
        case ({accept, pop})
            2'b10:   outstanding_next = outstanding + COUNT_BITS'(1);
            2'b01:   outstanding_next = outstanding - COUNT_BITS'(1);
            default: outstanding_next = outstanding;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            write_pointer   <= '0;
            read_pointer    <= '0;
            fifo_count      <= '0;
            outstanding     <= '0;
            o_request_ready <= 1'b0;
        end else begin
            if (push) begin
                write_pointer <= (write_pointer == LAST_POINTER) ? '0
                                 : write_pointer + POINTER_BITS'(1);
            end
            if (pop) begin
                read_pointer <= (read_pointer == LAST_POINTER) ? '0
                                : read_pointer + POINTER_BITS'(1);
            end
            fifo_count  <= fifo_count_next;
            outstanding <= outstanding_next;
            // Counting outstanding (not just queued) requests bounds the
            // pipeline plus FIFO occupancy, so the FIFO cannot overflow.
            o_request_ready <= (outstanding_next < DEPTH_COUNT);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (!(push && !pop && fifo_count == DEPTH_COUNT))
                else $fatal(1, "response FIFO push while full");
            assert (!(pop && fifo_count == '0))
                else $fatal(1, "response FIFO pop while empty");
            assert (!(accept && !pop && outstanding == DEPTH_COUNT))
                else $fatal(1, "outstanding counter overflow");
            assert (!(pop && !accept && outstanding == '0))
                else $fatal(1, "outstanding counter underflow");
        end
    end

endmodule

// File: tb/tb_rice_bus_sram_responder.sv
// Testbench for rice_bus_sram_responder with default parameters.
// A word-array memory model and a queue of expected responses track every
// accepted request; every popped response is compared against the queue head.

module tb_rice_bus_sram_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_ready;
    logic        req_valid = 1'b0;
    logic [63:0] addr = '0;
    logic [7:0]  strb = '0;
    logic [63:0] wdata = '0;
    logic        rsp_ready = 1'b0;
    logic        rsp_valid;
    logic [63:0] rsp_data;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          pop_cnt = 0;
    logic        last_acc = 1'b0;
    logic [63:0] last_pop_data = '0;
    logic [63:0] exp_q [$];
    logic [63:0] ref_mem [1024];

    rice_bus_sram_responder dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .o_request_ready  (req_ready),
        .i_request_valid  (req_valid),
        .i_address        (addr),
        .i_strobe         (strb),
        .i_write_data     (wdata),
        .i_response_ready (rsp_ready),
        .o_response_valid (rsp_valid),
        .o_read_data      (rsp_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [63:0] a);
        return int'(a[12:3]);
    endfunction

    function automatic logic [63:0] rand_addr(input int w);
        logic [63:0] a;
        logic [9:0]  wi;
        a = {$urandom, $urandom};
        wi = 10'(w);
        a[12:3] = wi;
        return a;
    endfunction

    // One clock: evaluate handshakes at the falling edge, update the model,
    // then step past the rising edge.
    task automatic tick();
        logic acc;
        logic pop;
        int   w;
        @(negedge clk);
        acc = req_valid && req_ready;
        pop = rsp_valid && rsp_ready;
        if (pop) begin
            if (exp_q.size() == 0) check("rsp_unexpected", 64'd1, 64'd0);
            else check("rsp_data", rsp_data, exp_q.pop_front());
            last_pop_data = rsp_data;
            pop_cnt++;
        end
        if (acc) begin
            w = widx(addr);
            if (strb != 8'h00) begin
                for (int b = 0; b < 8; b++)
                    if (strb[b]) ref_mem[w][8*b +: 8] = wdata[8*b +: 8];
                exp_q.push_back(64'd0);
            end else begin
                exp_q.push_back(ref_mem[w]);
            end
        end
        last_acc = acc;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d);
        req_valid = 1'b1;
        addr = a;
        strb = s;
        wdata = d;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (last_acc) break;
        end
        if (!last_acc) check("send_timeout", 64'd0, 64'd1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) tick();
        check("drain_left", 64'(exp_q.size()), 64'd0);
        check("drain_valid", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        int c0;
        int p0;
        int idx;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_data", rsp_data, 64'd0);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        check("ready_after_edge", 64'(req_ready), 64'd1);

        // Single write then read with latency check
        rsp_ready = 1'b1;
        send(64'h40, 8'hFF, 64'h0123_4567_89AB_CDEF);
        drain();
        check("write_rsp_zero", last_pop_data, 64'd0);
        rsp_ready = 1'b0;
        send(64'h40, 8'h00, 64'd0);
        check("latency_not_early", 64'(rsp_valid), 64'd0);
        tick();
        check("latency_valid", 64'(rsp_valid), 64'd1);
        check("read_data_head", rsp_data, 64'h0123_4567_89AB_CDEF);
        drain();
        check("read_popped", last_pop_data, 64'h0123_4567_89AB_CDEF);

        // Partial strobe
        send(64'h80, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        send(64'h80, 8'h0F, 64'd0);
        send(64'h80, 8'h00, 64'd0);
        drain();
        check("partial_strobe", last_pop_data, 64'hFFFF_FFFF_0000_0000);

        // Aliasing
        send(64'h8, 8'hFF, 64'hA5);
        send(64'h2008, 8'h00, 64'd0);
        drain();
        check("alias_read", last_pop_data, 64'hA5);

        // Initialise words 0..63 for later random reads
        for (int w = 0; w < 64; w++) send(rand_addr(w), 8'hFF, {$urandom, $urandom});
        drain();

        // Backpressure
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        strb = 8'h00;
        idx = 0;
        p0 = pop_cnt;
        for (int i = 0; i < 10; i++) begin
            addr = rand_addr(idx + 20);
            tick();
            if (last_acc) idx++;
        end
        check("bp_accepted", 64'(idx), 64'd4);
        check("bp_ready_low", 64'(req_ready), 64'd0);
        check("bp_no_pop", 64'(pop_cnt - p0), 64'd0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 40 && idx < 6; i++) begin
            addr = rand_addr(idx + 20);
            tick();
            if (last_acc) idx++;
        end
        req_valid = 1'b0;
        check("bp_remaining_accepted", 64'(idx), 64'd6);
        drain();
        check("bp_total_pops", 64'(pop_cnt - p0), 64'd6);

        // Full throughput: alternating write/read, one request per cycle
        rsp_ready = 1'b1;
        c0 = cyc;
        p0 = pop_cnt;
        for (int k = 0; k < 32; k++) begin
            if (k % 2 == 0) send(rand_addr(100 + k / 2), 8'hFF, {$urandom, $urandom});
            else            send(rand_addr(100 + k / 2), 8'h00, 64'd0);
        end
        check("thru_cycles", 64'(cyc - c0), 64'd32);
        tick();
        tick();
        check("thru_pops", 64'(pop_cnt - p0), 64'd32);
        drain();

        // Randomized traffic over initialised words
        req_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!req_valid || last_acc) begin
                req_valid = ($urandom_range(0, 3) != 0);
                addr = rand_addr($urandom_range(0, 63));
                strb = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
                wdata = {$urandom, $urandom};
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        req_valid = 1'b0;
        drain();

        // Reset mid-flight
        rsp_ready = 1'b0;
        send(rand_addr(8), 8'h00, 64'd0);
        send(rand_addr(9), 8'h00, 64'd0);
        send(rand_addr(10), 8'h00, 64'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midrst_req_ready", 64'(req_ready), 64'd0);
        check("midrst_rsp_data", rsp_data, 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("midrst_ready_held", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        check("midrst_ready_back", 64'(req_ready), 64'd1);
        check("midrst_valid_clear", 64'(rsp_valid), 64'd0);
        rsp_ready = 1'b1;
        send(rand_addr(8), 8'h00, 64'd0);
        drain();
        check("midrst_mem_kept", last_pop_data, ref_mem[8]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
